// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO read-mode enum and elaboration helper for sync_fifo_prog.
package fifo_pkg;
   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage array, synchronous write, asynchronous read.
module fifo_ram #(
   parameter int DEPTH = 16,
   parameter int DW = 8
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);
   logic [DW-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: synchronous FIFO, programmable almost thresholds, STD/FWFT read mode, flush, sticky errors.
// Define SYNC_FIFO_PARITY_EN to store an even-parity bit per word and expose parity_err.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int         DEPTH = 16,
   parameter int         WIDTH = 8,
   parameter fifo_mode_e MODE  = FIFO_STD,
   localparam int        CW    = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             flush,
   input  logic [CW-1:0]    af_thresh,
   input  logic [CW-1:0]    ae_thresh,
   input  logic             clr_err,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow
`ifdef SYNC_FIFO_PARITY_EN
   , output logic           parity_err
`endif
);
`ifdef SYNC_FIFO_PARITY_EN
   localparam int DW = WIDTH + 1;
`else
   localparam int DW = WIDTH;
`endif
   if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $error("sync_fifo_prog: DEPTH must be a power of 2 and >= 4");
   end
   logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic [DW-1:0] wdata, rdata, word, dout_q, dout_d;
   logic          dv_q, dv_d, ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;
`ifdef SYNC_FIFO_PARITY_EN
   assign wdata = {^din, din};
   assign parity_err = dout_valid && ^word;
`else
   assign wdata = din;
`endif
   fifo_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (wr_acc && !flush),
      .waddr (wr_ptr_q[CW-2:0]),
      .wdata (wdata),
      .raddr (rd_ptr_q[CW-2:0]),
      .rdata (rdata)
   );
   assign count        = count_q;
   assign full         = count_q == CW'(DEPTH);
   assign empty        = count_q == '0;
   assign almost_full  = count_q >= af_thresh;
   assign almost_empty = count_q <= ae_thresh;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign word         = (MODE == FIFO_FWFT) ? rdata : dout_q;
   assign dout         = word[WIDTH-1:0];
   assign dout_valid   = (MODE == FIFO_FWFT) ? !empty : dv_q;
   // flush overrides accepted reads/writes but leaves the sticky error flags alone
   always_comb begin
      wr_acc   = wr_en && !full;
      rd_acc   = rd_en && !empty;
      wr_ptr_d = flush ? '0 : wr_ptr_q + CW'(wr_acc);
      rd_ptr_d = flush ? '0 : rd_ptr_q + CW'(rd_acc);
      count_d  = flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
      dv_d     = rd_acc && !flush;
      dout_d   = dv_d ? rdata : dout_q;
      ovf_d    = (wr_en && full) || (ovf_q && !clr_err);
      unf_d    = (rd_en && empty) || (unf_q && !clr_err);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: STD and FWFT instances on shared stimulus, checked by a queue-based reference model.
module tb_sync_fifo_prog;
   import fifo_pkg::*;
   localparam int DEPTH = 16;
   localparam int CW = 5;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, wr_en, rd_en, flush, clr_err;
   logic [7:0] din;
   logic [CW-1:0] af_thresh, ae_thresh;
   logic [7:0] s_dout, f_dout;
   logic [CW-1:0] s_count, f_count;
   logic s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
`ifdef SYNC_FIFO_PARITY_EN
   logic s_pe, f_pe;
`endif
   sync_fifo_prog #(.DEPTH(DEPTH), .WIDTH(8), .MODE(FIFO_STD)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout),
      .dout_valid(s_dv), .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clr_err(clr_err), .count(s_count), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
`ifdef SYNC_FIFO_PARITY_EN
      , .parity_err(s_pe)
`endif
   );
   sync_fifo_prog #(.DEPTH(DEPTH), .WIDTH(8), .MODE(FIFO_FWFT)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout),
      .dout_valid(f_dv), .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clr_err(clr_err), .count(f_count), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
`ifdef SYNC_FIFO_PARITY_EN
      , .parity_err(f_pe)
`endif
   );
   int n_cmp = 0, n_bad = 0;
   logic [7:0] q[$];
   bit m_ovf, m_unf, m_dv;
   logic [7:0] m_dout;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask
   // Reference: FIFO as a queue; all decisions made on the pre-edge occupancy.
   task automatic model_update();
      int n = q.size();
      if (rst) begin
         q.delete();
         m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = 8'h00;
      end else begin
         m_ovf = (wr_en && n == DEPTH) || (m_ovf && !clr_err);
         m_unf = (rd_en && n == 0) || (m_unf && !clr_err);
         if (flush) begin
            q.delete();
            m_dv = 0;
         end else begin
            m_dv = rd_en && n > 0;
            if (m_dv) m_dout = q.pop_front();
            if (wr_en && n < DEPTH) q.push_back(din);
         end
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask
   task automatic check_model();
      int n = q.size();
      chk("std count", s_count, n);
      chk("std full", s_full, n == DEPTH);
      chk("std empty", s_empty, n == 0);
      chk("std almost_full", s_af, n >= af_thresh);
      chk("std almost_empty", s_ae, n <= ae_thresh);
      chk("std overflow", s_ovf, m_ovf);
      chk("std underflow", s_unf, m_unf);
      chk("std dout_valid", s_dv, m_dv);
      chk("std dout", s_dout, m_dout);
      chk("fwft count", f_count, n);
      chk("fwft flags", {f_full, f_empty, f_af, f_ae}, {n == DEPTH, n == 0, n >= af_thresh, n <= ae_thresh});
      chk("fwft errors", {f_ovf, f_unf}, {m_ovf, m_unf});
      chk("fwft dout_valid", f_dv, n > 0);
      if (n > 0) chk("fwft dout", f_dout, q[0]);
`ifdef SYNC_FIFO_PARITY_EN
      chk("parity_err", {s_pe, f_pe}, 2'b00);
`endif
   endtask
   task automatic drive(bit w, bit r, logic [7:0] d);
      wr_en = w; rd_en = r; din = d; flush = 0; clr_err = 0; rst = 0;
   endtask
   typedef struct {
      bit rst, flush, wr, rd, clr;
      logic [7:0] din;
      int e_count;
      bit e_empty, e_unf, e_dv;
      logic [7:0] e_dout;
   } vec_t;
   vec_t tbl[12];
   initial begin
      rst = 1; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; din = 0;
      af_thresh = 12; ae_thresh = 3;
      //           rst f  w  r  c  din    cnt emp unf dv dout
      tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00};
      tbl[1]  = '{0, 0, 1, 0, 0, 8'hA5, 1, 0, 0, 0, 8'h00};
      tbl[2]  = '{0, 0, 1, 0, 0, 8'h3C, 2, 0, 0, 0, 8'h00};
      tbl[3]  = '{0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 8'hA5};
      tbl[4]  = '{0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'hA5};
      tbl[5]  = '{0, 0, 1, 1, 0, 8'h11, 1, 0, 0, 1, 8'h3C};
      tbl[6]  = '{0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 8'h11};
      tbl[7]  = '{0, 0, 0, 1, 0, 8'h00, 0, 1, 1, 0, 8'h11};
      tbl[8]  = '{0, 0, 1, 1, 0, 8'h22, 1, 0, 1, 0, 8'h11};
      tbl[9]  = '{0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h11};
      tbl[10] = '{0, 1, 1, 0, 0, 8'h33, 0, 1, 0, 0, 8'h11};
      tbl[11] = '{0, 0, 0, 1, 0, 8'h00, 0, 1, 1, 0, 8'h11};
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; flush = tbl[i].flush; wr_en = tbl[i].wr;
         rd_en = tbl[i].rd; clr_err = tbl[i].clr; din = tbl[i].din;
         tick();
         chk($sformatf("vec%0d count", i), s_count, tbl[i].e_count);
         chk($sformatf("vec%0d empty", i), s_empty, tbl[i].e_empty);
         chk($sformatf("vec%0d underflow", i), s_unf, tbl[i].e_unf);
         chk($sformatf("vec%0d dout_valid", i), s_dv, tbl[i].e_dv);
         chk($sformatf("vec%0d dout", i), s_dout, tbl[i].e_dout);
      end
      // reset state, then fill 0..15 with threshold crossings checked every cycle
      rst = 1; tick(); check_model();
      chk("reset af", s_af, 0);
      for (int i = 0; i < DEPTH; i++) begin drive(1, 0, 8'(i)); tick(); check_model(); end
      chk("fill full", s_full, 1);
      chk("fill count", s_count, 16);
      drive(1, 1, 8'hEE); tick(); check_model();
      chk("full wr+rd count", s_count, 15);
      chk("full wr+rd overflow", s_ovf, 1);
      for (int i = 0; i < 15; i++) begin drive(0, 1, 0); tick(); check_model(); end
      chk("drain empty", s_empty, 1);
      drive(1, 1, 8'h77); tick(); check_model();
      chk("empty wr+rd count", s_count, 1);
      chk("empty wr+rd underflow", s_unf, 1);
      drive(0, 0, 0); clr_err = 1; tick(); check_model();
      chk("clr_err", {s_ovf, s_unf}, 2'b00);
      // wrap: three passes of 12 in / 12 out
      rst = 1; tick();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 12; i++) begin drive(1, 0, 8'(p * 16 + i)); tick(); check_model(); end
         for (int i = 0; i < 12; i++) begin drive(0, 1, 0); tick(); check_model(); end
      end
      chk("wrap count", s_count, 0);
      // FWFT head appears one cycle after the write with no rd_en
      drive(1, 0, 8'hA5); tick(); check_model();
      chk("fwft head", {f_dv, f_dout}, {1'b1, 8'hA5});
      drive(0, 1, 0); tick(); check_model();
      chk("fwft pop empty", f_empty, 1);
      // flush with wr_en at count 7, then rst mid-fill
      for (int i = 0; i < 7; i++) begin drive(1, 0, 8'(i + 40)); tick(); end
      drive(1, 0, 8'h99); flush = 1; tick(); check_model();
      chk("flush count", s_count, 0);
      for (int i = 0; i < 5; i++) begin drive(1, 0, 8'(i)); tick(); end
      drive(1, 0, 8'h55); rst = 1; tick(); check_model();
      chk("rst mid-fill", {s_count, s_empty, s_dv, s_dout}, {5'd0, 1'b1, 1'b0, 8'h00});
      // randomized traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom));
         flush = $urandom_range(0, 63) == 0;
         clr_err = $urandom_range(0, 31) == 0;
         rst = $urandom_range(0, 499) == 0;
         if ($urandom_range(0, 99) == 0) begin
            af_thresh = CW'($urandom_range(0, 18));
            ae_thresh = CW'($urandom_range(0, 18));
         end
         tick();
         check_model();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
